// File: rtl/spi_frame_decoder.sv
// Oversampling SPI decoder: synchronises the SPI pins into clk, supports all
// CPOL/CPHA modes and both bit orders, and emits completed MOSI/MISO words as strobes.
module spi_frame_decoder #(
    parameter int WORD_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic              miso,
    output logic [WORD_W-1:0] out_mosi,
    output logic [WORD_W-1:0] out_miso,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam int PIN_SCK  = 0;
    localparam int PIN_CS_N = 1;
    localparam int PIN_MOSI = 2;
    localparam int PIN_MISO = 3;
    // cs_n idles high, so its synchroniser resets to 1 to avoid a false frame_start
    localparam logic [3:0] PIN_RST = 4'b0010;

    logic [3:0] pin_raw;
    logic [3:0] pin_sync;

    assign pin_raw = {miso, mosi, cs_n, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain_reg <= {SYNC_STAGES{PIN_RST[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
                end
            end

            assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic miso_s;

    assign sck_s  = pin_sync[PIN_SCK];
    assign cs_s   = pin_sync[PIN_CS_N];
    assign mosi_s = pin_sync[PIN_MOSI];
    assign miso_s = pin_sync[PIN_MISO];

    logic sck_prev_reg;
    logic cs_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b1;
        end else begin
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_s;
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg;

    logic [0:0]        state_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic              lsb_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WORD_W-1:0] shift_mosi_reg;
    logic [WORD_W-1:0] shift_miso_reg;

    logic              sample_edge;
    logic              bit_take;
    logic              word_done;
    logic [WORD_W-1:0] shift_mosi_next;
    logic [WORD_W-1:0] shift_miso_next;
    logic [IDX_W-1:0]  idx_next;

    // Modes 0 and 3 sample on rising SCK, modes 1 and 2 on falling SCK
    assign sample_edge = (cpol_reg ^ cpha_reg) ? sck_fall : sck_rise;
    assign bit_take    = (state_reg == ST_ACTIVE) && en && !cs_s && sample_edge;
    assign word_done   = bit_take && (cnt_reg == CNT_LAST);
    assign idx_next    = (&idx_reg) ? idx_reg : idx_reg + 1'b1;

    always_comb begin
        shift_mosi_next = shift_mosi_reg;
        shift_miso_next = shift_miso_reg;
        if (lsb_reg) begin
            shift_mosi_next = {mosi_s, shift_mosi_reg[WORD_W-1:1]};
            shift_miso_next = {miso_s, shift_miso_reg[WORD_W-1:1]};
        end else begin
            shift_mosi_next = {shift_mosi_reg[WORD_W-2:0], mosi_s};
            shift_miso_next = {shift_miso_reg[WORD_W-2:0], miso_s};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cpol_reg       <= 1'b0;
            cpha_reg       <= 1'b0;
            lsb_reg        <= 1'b0;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shift_mosi_reg <= '0;
            shift_miso_reg <= '0;
            out_mosi       <= '0;
            out_miso       <= '0;
            out_idx        <= '0;
            out_valid      <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (en && cs_fall) begin
                        state_reg      <= ST_ACTIVE;
                        frame_start    <= 1'b1;
                        cpol_reg       <= cpol;
                        cpha_reg       <= cpha;
                        lsb_reg        <= lsb_first;
                        cnt_reg        <= '0;
                        idx_reg        <= '0;
                        shift_mosi_reg <= '0;
                        shift_miso_reg <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!en) begin
                        state_reg <= ST_IDLE;
                    end else if (cs_rise) begin
                        // A sample edge coinciding with cs_n rise is dropped; judge on prior count
                        state_reg <= ST_IDLE;
                        frame_end <= 1'b1;
                        frame_err <= (cnt_reg != '0);
                    end else if (bit_take) begin
                        shift_mosi_reg <= shift_mosi_next;
                        shift_miso_reg <= shift_miso_next;
                        if (word_done) begin
                            out_mosi  <= shift_mosi_next;
                            out_miso  <= shift_miso_next;
                            out_idx   <= idx_reg;
                            out_valid <= 1'b1;
                            cnt_reg   <= '0;
                            idx_reg   <= idx_next;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
